icache_dm_line: RTL and testbench
=================================

Name: icache_dm_line

Overview:
Parametrised direct-mapped instruction cache with multi-word lines. It sits between the IF stage and mem_ctrl. Hits return from the array with one registered cycle of latency. Misses run a refill FSM that fetches a whole line word by word from mem_ctrl. Adds a one-cycle flush (fence.i) and explicit request/response handshakes.

Parameters:
ADDR_W, 32, address width in bits
INST_W, 32, instruction/word width in bits
INDEX_BITS, 7, log2 of the number of cache lines
LINE_WORDS, 4, words per line; power of two, >=1; OFF_BITS = log2(LINE_WORDS)
TAG_BITS (derived, localparam) = ADDR_W - INDEX_BITS - OFF_BITS - 2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  IF requests an instruction at req_addr
req_addr  in  ADDR_W  word-aligned fetch address; held stable by IF until resp_valid
req_ready  out  1  cache can accept a request (state IDLE)
flush  in  1  invalidate all lines
resp_valid  out  1  one-cycle pulse: resp_inst/resp_addr valid
resp_inst  out  INST_W  fetched instruction
resp_addr  out  ADDR_W  address of resp_inst
mem_req  out  1  refill word request to mem_ctrl, held high during REFILL
mem_addr  out  ADDR_W  address of the current refill word
mem_data  in  INST_W  word returned by mem_ctrl
mem_valid  in  1  mem_data valid for mem_addr; one word per pulse

Behaviour:
- Address split: [1:0] ignored; off = [OFF_BITS+1:2]; idx = [OFF_BITS+INDEX_BITS+1:OFF_BITS+2]; tag = upper TAG_BITS.
- Storage: data[2^INDEX_BITS][LINE_WORDS], tag[2^INDEX_BITS], valid[2^INDEX_BITS].
- Reset (asynchronous, any state): all valid bits = 0; state = IDLE; refill counter = 0; resp_valid = 0; resp_inst = 0; resp_addr = 0; mem_req = 0; mem_addr = 0; flush_pend = 0. req_ready = 1 after reset. Reset mid-refill aborts it; mem_req drops immediately; no line becomes valid.
- FSM states: IDLE, REFILL, RESP.
- IDLE, req_valid, hit (valid[idx] && tag match):
  - next edge: resp_valid = 1, resp_inst = data[idx][off], resp_addr = req_addr; stay IDLE.
  - Back-to-back hits give one response per cycle.
- IDLE, req_valid, miss:
  - next edge: latch req_addr; cnt = 0; mem_addr = {tag, idx, 0, 2'b00}; mem_req = 1; go to REFILL.
- REFILL:
  - On mem_valid: data[idx][cnt] = mem_data; cnt++; mem_addr += 4.
  - When cnt == LINE_WORDS-1 and mem_valid: write tag; valid[idx] = !(flush_pend || flush); mem_req = 0; go to RESP.
  - req_valid is ignored (req_ready = 0).
- RESP: resp_valid = 1, resp_inst = word at latched off from the filled line (bypass of the refill word captured this line), resp_addr = latched addr; next state IDLE.
- resp_valid is a single-cycle pulse; it is 0 in every other cycle.
- Flush:
  - In IDLE or RESP: all valid bits cleared on the same edge.
  - A request in the same cycle as flush is treated as a miss.
  - In REFILL: all valid bits cleared and flush_pend = 1. The refill completes and the response is still delivered, but the line is not marked valid. flush_pend is cleared on entry to IDLE.
- mem_valid while not in REFILL: ignored.
- mem_addr wrap at top of address space: modulo 2^ADDR_W.
- LINE_WORDS = 1 degenerates to a single-word refill (cnt width forced to >=1 bit).

Test Plan:
- Reset then cold miss: req_addr=0x00001004 -> req_ready=0; mem_addr 0x1000, 0x1004, 0x1008, 0x100C with mem_data 0xA0..0xA3 -> resp_valid one cycle after the 4th mem_valid with resp_inst=0xA1, resp_addr=0x1004.
- Hit after fill: req_addr=0x0000100C -> resp_valid next cycle, resp_inst=0xA3, mem_req stays 0. Then 0x1000 and 0x1008 on consecutive cycles -> 0xA0, 0xA2 on consecutive cycles.
- Conflict: req 0x00001800 (same idx 0, tag 3 vs 2) -> refill 0x1800..0x180C. A subsequent 0x1000 misses again.
- Flush mid-refill: assert flush during the 2nd refill word of 0x2000 -> response still delivered; a following request to 0x2000 misses. The 0x1000 line also misses.
- Async reset mid-refill: assert rst after 2 words -> mem_req=0, resp_valid=0 immediately. After release, a request to the same address misses with a full 4-word refill.
- Parameter sweep LINE_WORDS=1, INDEX_BITS=4: miss on 0x40 -> single mem_addr 0x40. Then hit on 0x40 next request.

Source files
------------

// File: rtl/icache_dm_line.sv
// Direct-mapped instruction cache with multi-word lines. Hits answer one registered cycle
// later; misses refill the whole line word by word from mem_ctrl before responding.
module icache_dm_line #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INST_W     = 32,
  parameter int unsigned INDEX_BITS = 7,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic [INST_W-1:0] resp_inst,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_data,
  input  logic              mem_valid
);

  localparam int unsigned OFF_BITS  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 0;
  localparam int unsigned CNT_W     = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int unsigned TAG_BITS  = ADDR_W - INDEX_BITS - OFF_BITS - 2;
  localparam int unsigned NUM_LINES = 1 << INDEX_BITS;
  localparam int unsigned WIX_W     = INDEX_BITS + OFF_BITS;

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRefill, StResp} state_e;

  // Address field extraction via shifts so LINE_WORDS == 1 needs no zero-width slices.
  function automatic logic [CNT_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return CNT_W'((a >> 2) & OFF_MASK);
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return INDEX_BITS'(a >> (OFF_BITS + 2));
  endfunction

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return TAG_BITS'(a >> (OFF_BITS + INDEX_BITS + 2));
  endfunction

  function automatic logic [WIX_W-1:0] word_ix(input logic [INDEX_BITS-1:0] idx,
                                               input logic [CNT_W-1:0]      off);
    return (WIX_W'(idx) << OFF_BITS) | WIX_W'(off);
  endfunction

  logic [INST_W-1:0]   data_q [NUM_LINES * LINE_WORDS];
  logic [TAG_BITS-1:0] tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                resp_valid_q, resp_valid_d;
  logic [INST_W-1:0]   resp_inst_q, resp_inst_d;
  logic [ADDR_W-1:0]   resp_addr_q, resp_addr_d;
  logic                flush_pend_q, flush_pend_d;
  logic                data_we, tag_we;

  logic [CNT_W-1:0]      req_off, lat_off;
  logic [INDEX_BITS-1:0] req_idx, lat_idx;
  logic [TAG_BITS-1:0]   req_tag, lat_tag;
  logic                  hit;

  assign req_off = addr_off(req_addr);
  assign req_idx = addr_idx(req_addr);
  assign req_tag = addr_tag(req_addr);
  assign lat_off = addr_off(addr_q);
  assign lat_idx = addr_idx(addr_q);
  assign lat_tag = addr_tag(addr_q);
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = 1'b0;
    resp_inst_d  = resp_inst_q;
    resp_addr_d  = resp_addr_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          // A flush in the same cycle forces the miss path.
          if (hit && !flush) begin
            resp_valid_d = 1'b1;
            resp_inst_d  = data_q[word_ix(req_idx, req_off)];
            resp_addr_d  = req_addr;
          end else begin
            addr_d     = req_addr;
            cnt_d      = '0;
            mem_addr_d = req_addr & ~LINE_MASK;
            mem_req_d  = 1'b1;
            state_d    = StRefill;
          end
        end
      end
      StRefill: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_valid) begin
          data_we    = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          mem_addr_d = mem_addr_q + ADDR_W'(4);
          if (cnt_q == LAST_CNT) begin
            tag_we       = 1'b1;
            mem_req_d    = 1'b0;
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_addr_d  = addr_q;
            // The requested word may be the one arriving on this very edge.
            resp_inst_d  = (cnt_q == lat_off) ? mem_data
                                              : data_q[word_ix(lat_idx, lat_off)];
          end
        end
      end
      StResp: begin
        state_d      = StIdle;
        flush_pend_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if (flush) valid_d = '0;
    if (tag_we) valid_d[lat_idx] = !(flush_pend_q || flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= '0;
      resp_addr_q  <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_inst_q  <= resp_inst_d;
      resp_addr_q  <= resp_addr_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  // Arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (data_we) data_q[word_ix(lat_idx, cnt_q)] <= mem_data;
    if (tag_we)  tag_q[lat_idx] <= lat_tag;
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;
  assign resp_addr  = resp_addr_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache_dm_line.sv
// Directed bench for icache_dm_line: a 4-word-line instance and a 1-word-line instance,
// driven #1 after each rising edge and checked with immediate assertions.
module tb_icache_dm_line;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, flush, mem_valid;
  logic [31:0] req_addr, mem_data;
  logic        req_ready, resp_valid, mem_req;
  logic [31:0] resp_inst, resp_addr, mem_addr;

  logic        b_req_valid, b_flush, b_mem_valid;
  logic [31:0] b_req_addr, b_mem_data;
  logic        b_req_ready, b_resp_valid, b_mem_req;
  logic [31:0] b_resp_inst, b_resp_addr, b_mem_addr;

  int checks = 0;
  int passes = 0;

  icache_dm_line #(
    .ADDR_W(32), .INST_W(32), .INDEX_BITS(7), .LINE_WORDS(4)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .flush(flush), .resp_valid(resp_valid),
    .resp_inst(resp_inst), .resp_addr(resp_addr), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid)
  );

  icache_dm_line #(
    .ADDR_W(32), .INST_W(32), .INDEX_BITS(4), .LINE_WORDS(1)
  ) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_addr(b_req_addr),
    .req_ready(b_req_ready), .flush(b_flush), .resp_valid(b_resp_valid),
    .resp_inst(b_resp_inst), .resp_addr(b_resp_addr), .mem_req(b_mem_req),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_valid(b_mem_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one word per cycle; checks the address sequence and the final response.
  task automatic do_refill(input string tag, input logic [31:0] base, input logic [31:0] d0,
                           input logic [31:0] exp_inst, input logic [31:0] exp_addr);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
      chk({tag, "_mem_addr"}, mem_addr, base + 32'(i * 4));
      chk({tag, "_no_resp"}, {31'd0, resp_valid}, 32'd0);
      mem_data  = d0 + 32'(i);
      mem_valid = 1'b1;
      tick();
      mem_valid = 1'b0;
    end
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_resp_inst"}, resp_inst, exp_inst);
    chk({tag, "_resp_addr"}, resp_addr, exp_addr);
    chk({tag, "_mem_req_off"}, {31'd0, mem_req}, 32'd0);
    req_valid = 1'b0;
    tick();
    chk({tag, "_pulse_end"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Present a request for one edge and check it was taken as a miss.
  task automatic miss_req(input string tag, input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    chk({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_miss_no_resp"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; flush = 1'b0; mem_valid = 1'b0; mem_data = '0;
    b_req_valid = 1'b0; b_req_addr = '0; b_flush = 1'b0; b_mem_valid = 1'b0; b_mem_data = '0;
    tick();
    tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_inst", resp_inst, 32'd0);
    chk("rst_resp_addr", resp_addr, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_b_ready", {31'd0, b_req_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // Cold miss; req_valid stays high through the refill.
    miss_req("cold", 32'h0000_1004);
    do_refill("cold", 32'h0000_1000, 32'hA0, 32'hA1, 32'h0000_1004);

    // Hits, including back-to-back.
    req_valid = 1'b1; req_addr = 32'h0000_100C;
    tick();
    chk("hit0_valid", {31'd0, resp_valid}, 32'd1);
    chk("hit0_inst", resp_inst, 32'hA3);
    chk("hit0_addr", resp_addr, 32'h0000_100C);
    chk("hit0_mem_req", {31'd0, mem_req}, 32'd0);
    req_addr = 32'h0000_1000;
    tick();
    chk("hit1_valid", {31'd0, resp_valid}, 32'd1);
    chk("hit1_inst", resp_inst, 32'hA0);
    req_addr = 32'h0000_1008;
    tick();
    chk("hit2_valid", {31'd0, resp_valid}, 32'd1);
    chk("hit2_inst", resp_inst, 32'hA2);
    chk("hit2_addr", resp_addr, 32'h0000_1008);
    req_valid = 1'b0;
    tick();
    chk("hit_pulse_end", {31'd0, resp_valid}, 32'd0);

    // Conflict on index 0, then the evicted line misses again.
    miss_req("confl", 32'h0000_1800);
    do_refill("confl", 32'h0000_1800, 32'hB0, 32'hB0, 32'h0000_1800);
    miss_req("evict", 32'h0000_1000);
    do_refill("evict", 32'h0000_1000, 32'hA0, 32'hA0, 32'h0000_1000);

    // Line at index 1, confirmed resident.
    miss_req("idx1", 32'h0000_3010);
    do_refill("idx1", 32'h0000_3010, 32'hD0, 32'hD0, 32'h0000_3010);
    req_valid = 1'b1; req_addr = 32'h0000_3014;
    tick();
    chk("idx1_hit_valid", {31'd0, resp_valid}, 32'd1);
    chk("idx1_hit_inst", resp_inst, 32'hD1);
    req_valid = 1'b0;
    tick();

    // Flush during the second refill word.
    miss_req("fl", 32'h0000_2000);
    mem_data = 32'hC0; mem_valid = 1'b1;
    tick();
    mem_data = 32'hC1; flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_data = 32'hC2;
    tick();
    mem_data = 32'hC3;
    tick();
    mem_valid = 1'b0;
    chk("fl_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("fl_resp_inst", resp_inst, 32'hC0);
    chk("fl_resp_addr", resp_addr, 32'h0000_2000);
    req_valid = 1'b0;
    tick();
    miss_req("fl_again", 32'h0000_2000);
    do_refill("fl_again", 32'h0000_2000, 32'hC0, 32'hC0, 32'h0000_2000);
    miss_req("fl_other", 32'h0000_3010);
    do_refill("fl_other", 32'h0000_3010, 32'hD0, 32'hD0, 32'h0000_3010);

    // Flush with a request in IDLE is a miss; the refilled line is then valid.
    flush = 1'b1;
    miss_req("flreq", 32'h0000_3010);
    flush = 1'b0;
    do_refill("flreq", 32'h0000_3010, 32'hD0, 32'hD0, 32'h0000_3010);
    req_valid = 1'b1; req_addr = 32'h0000_3010;
    tick();
    chk("flreq_hit_valid", {31'd0, resp_valid}, 32'd1);
    chk("flreq_hit_inst", resp_inst, 32'hD0);
    req_valid = 1'b0;
    tick();

    // Refill address wraps past the top of the address space.
    miss_req("wrap", 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_mem_addr", mem_addr, 32'hFFFF_FFF0 + 32'(i * 4));
      mem_data = 32'h10 + 32'(i); mem_valid = 1'b1;
      tick();
      mem_valid = 1'b0;
    end
    chk("wrap_mem_addr_end", mem_addr, 32'h0000_0000);
    chk("wrap_resp_inst", resp_inst, 32'h12);
    req_valid = 1'b0;
    tick();

    // Asynchronous reset after two refill words.
    miss_req("arst", 32'h0000_4000);
    mem_data = 32'hE0; mem_valid = 1'b1;
    tick();
    mem_data = 32'hE1;
    tick();
    mem_valid = 1'b0;
    chk("arst_pre_mem_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    miss_req("arst_again", 32'h0000_4000);
    do_refill("arst_again", 32'h0000_4000, 32'hE0, 32'hE0, 32'h0000_4000);

    // Single-word lines, 16 entries.
    b_req_valid = 1'b1; b_req_addr = 32'h0000_0040;
    tick();
    chk("b_miss_mem_req", {31'd0, b_mem_req}, 32'd1);
    chk("b_miss_mem_addr", b_mem_addr, 32'h0000_0040);
    chk("b_miss_ready", {31'd0, b_req_ready}, 32'd0);
    b_mem_data = 32'h55; b_mem_valid = 1'b1;
    tick();
    b_mem_valid = 1'b0;
    chk("b_resp_valid", {31'd0, b_resp_valid}, 32'd1);
    chk("b_resp_inst", b_resp_inst, 32'h55);
    chk("b_resp_addr", b_resp_addr, 32'h0000_0040);
    chk("b_mem_req_off", {31'd0, b_mem_req}, 32'd0);
    b_req_valid = 1'b0;
    tick();
    b_req_valid = 1'b1;
    tick();
    chk("b_hit_valid", {31'd0, b_resp_valid}, 32'd1);
    chk("b_hit_inst", b_resp_inst, 32'h55);
    chk("b_hit_mem_req", {31'd0, b_mem_req}, 32'd0);
    b_req_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
